registro_deserial: RTL and testbench
====================================

Name: registro_deserial

Overview:
- Serial receiver for the bit stream that a universal shift register emits on S_OUT in PUSH mode.
- Collects WIDTH serial bits into a parallel word and restores the original bit order for either shift direction.
- Hands each word to a consumer through a one-word valid/ready holding buffer.
- Sits at the far end of a register-to-register serial link and is used for loopback checking of the shift-register datapath.

Parameters:
- WIDTH, 4, word length in bits. Must be 2 or more.
- CW, $clog2(WIDTH), bit-counter width. Derived; do not override.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET_L  input  1  reset, asynchronous, active-low; one clock domain only.
- ENB  input  1  shift enable; low freezes the receive state (stall).
- START  input  1  frame start; high in the same cycle as the first bit on S_IN.
- DIR  input  1  0 = MSB first (transmitter shifted left); 1 = LSB first (transmitter shifted right).
- S_IN  input  1  serial data, sampled at the rising edge.
- Q_READY  input  1  consumer accepts Q this cycle.
- Q  output  WIDTH  assembled word (holding buffer).
- Q_VALID  output  1  Q holds an unconsumed word.
- BUSY  output  1  a frame is in progress (state RECV).
- OVERRUN  output  1  sticky flag; a completed word was dropped.

Behaviour:
- Reset (async, RESET_L=0): state IDLE, bit count 0, shift register 0, Q=0, Q_VALID=0, BUSY=0, OVERRUN=0.
  - A reset in the middle of a frame discards the partial word.
  - After release, the block waits for a new START.
- State IDLE:
  - ENB=1 and START=1: sample S_IN as bit 0, latch DIR for the whole frame, count=1, go to RECV.
  - Otherwise: hold.
- State RECV:
  - ENB=1: sample S_IN and increment count.
  - Sample order: DIR latched 0 gives sh <= {sh[WIDTH-2:0], S_IN}; DIR latched 1 gives sh <= {S_IN, sh[WIDTH-1:1]}.
  - When the sampled bit is bit WIDTH-1, the frame completes: go to IDLE, count=0.
  - START is ignored while in RECV, including on the final-bit cycle.
- ENB=0 in any state: shift register, count, state and latched DIR all hold. The handshake still runs.
- Back-to-back frames: START may be asserted in the cycle right after a final bit, giving zero gap.
- BUSY is 1 exactly while state = RECV.
- Completion timing: the completed word (the shift-register next-value) goes to Q on the same edge that samples the final bit. Q_VALID is 1 from that edge.
- Total latency is WIDTH sampling edges, plus one extra edge per cycle with ENB=0.
- Holding-buffer rules, per edge, where C = frame completes this edge:
  - C and (Q_VALID=0 or Q_READY=1): Q <= new word, Q_VALID <= 1.
  - C and Q_VALID=1 and Q_READY=0: new word dropped, Q unchanged, OVERRUN <= 1.
  - Not C, Q_VALID=1 and Q_READY=1: Q_VALID <= 0. Q keeps its last value.
  - Q_READY while Q_VALID=0 has no effect.
- OVERRUN clears only on reset.
- The block never emits a partial word.

Decomposition:
- definitions.v holds the state codes (`RX_IDLE, `RX_RECV) and the direction codes (`MSB_FIRST = 0, `LSB_FIRST = 1), next to the existing mode codes.
- One sub-module is natural: registro_hold, the WIDTH-bit valid/ready holding buffer with overrun detect.
- The FSM, counter and shifter stay in the top module.

Test Plan (WIDTH=4):
- DIR=0, START with S_IN=1, then bits 0,1,1, ENB=1 → Q=4'b1011, Q_VALID=1 after the 4th edge, BUSY high for edges 1–3.
- DIR=1, same bit sequence 1,0,1,1 → Q=4'b1101, Q_VALID=1 after the 4th edge.
- DIR=0, stream 1,1,0,1 with ENB=0 for 2 cycles after bit 1 → Q=4'b1101, Q_VALID rises 2 edges later than without the stall.
- Q_READY=0, two back-to-back frames 4'hA then 4'h5 → Q stays 4'hA and OVERRUN=1.
  - Repeat with Q_READY=1 on the 2nd completion edge → Q=4'h5, OVERRUN=0.
- RESET_L pulsed low after 2 bits of a frame → all outputs 0 immediately.
  - The next frame 4'h9 with START after release → Q=4'h9.
- Loopback: LOAD 4'hC into the shift register, then PUSH DIR=0 for 4 cycles, START aligned to the first S_OUT bit → Q=4'hC.

Source files
------------

// File: rtl/registro_deserial_pkg.sv
// Shared state and direction codes for the serial-to-parallel receiver.
package registro_deserial_pkg;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_e;

    localparam logic MSB_FIRST = 1'b0;
    localparam logic LSB_FIRST = 1'b1;

endpackage : registro_deserial_pkg

// File: rtl/registro_hold.sv
// One-word valid/ready holding buffer; a word arriving while the buffer is full
// and not being drained is dropped and raises a sticky overrun flag.
module registro_hold
    import registro_deserial_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             complete_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] q_o,
    output logic             valid_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    // A completion on the same edge as a consume replaces the held word.
    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (complete_i) begin
            if (!valid_q || ready_i) begin
                q_d     = word_i;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign q_o       = q_q;
    assign valid_o   = valid_q;
    assign overrun_o = ovr_q;

endmodule : registro_hold

// File: rtl/registro_deserial.sv
// Serial receiver: assembles WIDTH bits from a shift-register S_OUT stream into
// a word in original bit order and hands it to a valid/ready holding buffer.
module registro_deserial
    import registro_deserial_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             ENB,
    input  logic             START,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic             Q_READY,
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID,
    output logic             BUSY,
    output logic             OVERRUN
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    rx_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             dir_q, dir_d;
    logic             busy_q;
    logic             frame_done;
    logic             dir_sel;
    logic [WIDTH-1:0] sh_next;

    // The first bit is shifted with the live DIR, later bits with the latched one.
    assign dir_sel = (state_q == RX_IDLE) ? DIR : dir_q;
    assign sh_next = (dir_sel == LSB_FIRST) ? {S_IN, sh_q[WIDTH-1:1]}
                                            : {sh_q[WIDTH-2:0], S_IN};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        dir_d      = dir_q;
        frame_done = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (ENB && START) begin
                    sh_d    = sh_next;
                    dir_d   = DIR;
                    cnt_d   = CW'(1);
                    state_d = RX_RECV;
                end
            end
            RX_RECV: begin
                if (ENB) begin
                    sh_d = sh_next;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d      = '0;
                        state_d    = RX_IDLE;
                        frame_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            dir_q   <= MSB_FIRST;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            dir_q   <= dir_d;
            busy_q  <= (state_d == RX_RECV);
        end
    end

    assign BUSY = busy_q;

    registro_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk        (CLK),
        .rst_n      (RESET_L),
        .complete_i (frame_done),
        .word_i     (sh_d),
        .ready_i    (Q_READY),
        .q_o        (Q),
        .valid_o    (Q_VALID),
        .overrun_o  (OVERRUN)
    );

endmodule : registro_deserial

// File: tb/tb_registro_deserial.sv
// Directed bench for registro_deserial (WIDTH=4) with hand-computed expectations.
module tb_registro_deserial;

    localparam int unsigned WIDTH = 4;

    logic             CLK = 1'b0;
    logic             RESET_L;
    logic             ENB;
    logic             START;
    logic             DIR;
    logic             S_IN;
    logic             Q_READY;
    logic [WIDTH-1:0] Q;
    logic             Q_VALID;
    logic             BUSY;
    logic             OVERRUN;

    int n_vec = 0;
    int n_err = 0;

    registro_deserial #(.WIDTH(WIDTH)) dut (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .ENB     (ENB),
        .START   (START),
        .DIR     (DIR),
        .S_IN    (S_IN),
        .Q_READY (Q_READY),
        .Q       (Q),
        .Q_VALID (Q_VALID),
        .BUSY    (BUSY),
        .OVERRUN (OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then settle 1ns past the rising edge.
    task automatic drive(input logic s, input logic st, input logic en, input logic rdy);
        S_IN    = s;
        START   = st;
        ENB     = en;
        Q_READY = rdy;
        @(posedge CLK);
        #1;
    endtask

    // seq[3] goes first; DIR is flipped after the first bit so only the latched value counts.
    task automatic send_frame(input logic d, input logic [3:0] seq, input logic rdy_last);
        for (int i = 0; i < 4; i++) begin
            DIR = (i == 0) ? d : ~d;
            drive(seq[3-i], (i == 0), 1'b1, (i == 3) ? rdy_last : 1'b0);
        end
        DIR = 1'b0;
    endtask

    task automatic consume();
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        Q_READY = 1'b0;
    endtask

    logic [3:0] tx;

    initial begin
        RESET_L = 1'b0;
        ENB = 1'b0; START = 1'b0; DIR = 1'b0; S_IN = 1'b0; Q_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_q",     32'(Q),       32'h0);
        chk("rst_valid", 32'(Q_VALID), 32'h0);
        chk("rst_busy",  32'(BUSY),    32'h0);
        chk("rst_ovr",   32'(OVERRUN), 32'h0);
        #3 RESET_L = 1'b1;
        @(posedge CLK); #1;

        // MSB first 1,0,1,1 with per-edge BUSY/valid checks
        DIR = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t1_busy_e1", 32'(BUSY), 32'h1);
        DIR = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_busy_e2", 32'(BUSY), 32'h1);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t1_busy_e3", 32'(BUSY), 32'h1);
        chk("t1_valid_e3", 32'(Q_VALID), 32'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t1_busy_e4",  32'(BUSY),    32'h0);
        chk("t1_valid_e4", 32'(Q_VALID), 32'h1);
        chk("t1_q",        32'(Q),       32'hB);
        DIR = 1'b0;
        consume();
        chk("t1_valid_cons", 32'(Q_VALID), 32'h0);
        chk("t1_q_kept",     32'(Q),       32'hB);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t1_ready_idle", 32'(Q_VALID), 32'h0);

        // LSB first, same bit sequence
        send_frame(1'b1, 4'b1011, 1'b0);
        chk("t2_valid", 32'(Q_VALID), 32'h1);
        chk("t2_q",     32'(Q),       32'hD);
        consume();

        // MSB first 1,1,0,1 with a two-cycle stall after bit 1; START during RECV ignored
        DIR = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        DIR = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_busy_stall",  32'(BUSY),    32'h1);
        chk("t3_valid_stall", 32'(Q_VALID), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_valid_e5", 32'(Q_VALID), 32'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t3_valid_e6", 32'(Q_VALID), 32'h1);
        chk("t3_q",        32'(Q),       32'hD);
        chk("t3_busy",     32'(BUSY),    32'h0);
        DIR = 1'b0;
        consume();

        // Back-to-back frames with no consumer: second word dropped
        send_frame(1'b0, 4'hA, 1'b0);
        chk("t4_q_first", 32'(Q), 32'hA);
        send_frame(1'b0, 4'h5, 1'b0);
        chk("t4_q_kept", 32'(Q),       32'hA);
        chk("t4_ovr",    32'(OVERRUN), 32'h1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_ovr_sticky", 32'(OVERRUN), 32'h1);

        // Reset clears the sticky flag
        #2 RESET_L = 1'b0;
        #1;
        chk("t5_rst_ovr", 32'(OVERRUN), 32'h0);
        #3 RESET_L = 1'b1;
        @(posedge CLK); #1;
        send_frame(1'b0, 4'hA, 1'b0);
        send_frame(1'b0, 4'h5, 1'b1);
        chk("t5_q",     32'(Q),       32'h5);
        chk("t5_valid", 32'(Q_VALID), 32'h1);
        chk("t5_ovr",   32'(OVERRUN), 32'h0);

        // Reset mid-frame after two bits
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        #2 RESET_L = 1'b0;
        #1;
        chk("t6_q",     32'(Q),       32'h0);
        chk("t6_valid", 32'(Q_VALID), 32'h0);
        chk("t6_busy",  32'(BUSY),    32'h0);
        #3 RESET_L = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6_idle_busy", 32'(BUSY), 32'h0);
        send_frame(1'b0, 4'h9, 1'b0);
        chk("t6_q9",     32'(Q),       32'h9);
        chk("t6_valid9", 32'(Q_VALID), 32'h1);
        consume();

        // Loopback from a shift register loaded with 0xC, pushing left (S_OUT = MSB)
        tx  = 4'hC;
        DIR = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(tx[3], (i == 0), 1'b1, 1'b0);
            tx = {tx[2:0], 1'b0};
        end
        chk("t7_q",     32'(Q),       32'hC);
        chk("t7_valid", 32'(Q_VALID), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_registro_deserial
